// File: rtl/jtag_pkg.sv
// Shared JTAG constants: capture LSB pattern, 4-bit default opcodes and the
// instruction-select enum used by the IR decode.
package jtag_pkg;

  localparam logic [1:0] CAPTURE_LSB = 2'b01;

  localparam logic [3:0] EXTEST_OP4 = 4'b0000;
  localparam logic [3:0] BYPASS_OP4 = 4'b1111;
  localparam logic [3:0] IDCODE_OP4 = 4'b0010;
  localparam logic [3:0] SAMPLE_OP4 = 4'b0001;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_SAMPLE,
    SEL_EXTEST
  } sel_e;

endpackage

// File: rtl/jtag_ir_param_if.sv
// TAP-to-IR signal bundle: TAP state enables and status in, shift/decode results out.
interface jtag_ir_param_if #(
  parameter int unsigned IR_WIDTH = 4
);
  localparam int unsigned ST_W = (IR_WIDTH > 2) ? IR_WIDTH - 2 : 1;

  logic                TDI;
  logic                CaptureIR;
  logic                ShiftIR;
  logic                UpdateIR;
  logic                TestLogicReset;
  logic [ST_W-1:0]     StatusIn;
  logic                TDO;
  logic [IR_WIDTH-1:0] Instruction;
  logic                SelBypass;
  logic                SelIdcode;
  logic                SelSample;
  logic                SelExtest;
  logic                ShiftErr;

  modport master (
    output TDI, CaptureIR, ShiftIR, UpdateIR, TestLogicReset, StatusIn,
    input  TDO, Instruction, SelBypass, SelIdcode, SelSample, SelExtest, ShiftErr
  );

  modport slave (
    input  TDI, CaptureIR, ShiftIR, UpdateIR, TestLogicReset, StatusIn,
    output TDO, Instruction, SelBypass, SelIdcode, SelSample, SelExtest, ShiftErr
  );

endinterface

// File: rtl/jtag_ir_decode.sv
// Combinational instruction decode into one-hot TDR selects; unknown opcodes select bypass.
module jtag_ir_decode
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH  = 4,
  parameter logic [IR_WIDTH-1:0]  IDCODE_OP = IR_WIDTH'(IDCODE_OP4),
  parameter logic [IR_WIDTH-1:0]  SAMPLE_OP = IR_WIDTH'(SAMPLE_OP4)
) (
  input  logic [IR_WIDTH-1:0] instr,
  output logic                sel_bypass,
  output logic                sel_idcode,
  output logic                sel_sample,
  output logic                sel_extest
);

  sel_e sel;

  always_comb begin
    sel = SEL_BYPASS;
    if (instr == '0) begin
      sel = SEL_EXTEST;
    end else if (instr == '1) begin
      sel = SEL_BYPASS;
    end else if (instr == IDCODE_OP) begin
      sel = SEL_IDCODE;
    end else if (instr == SAMPLE_OP) begin
      sel = SEL_SAMPLE;
    end
  end

  assign sel_bypass = (sel == SEL_BYPASS);
  assign sel_idcode = (sel == SEL_IDCODE);
  assign sel_sample = (sel == SEL_SAMPLE);
  assign sel_extest = (sel == SEL_EXTEST);

endmodule

// File: rtl/jtag_ir_param.sv
// Parametrised JTAG instruction register with capture/shift/update and decode.
// Optional short-shift detection is built when JTAG_IR_SHIFT_CHECK_EN is defined.
module jtag_ir_param
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH  = 4,
  parameter logic [IR_WIDTH-1:0]  IDCODE_OP = IR_WIDTH'(IDCODE_OP4),
  parameter logic [IR_WIDTH-1:0]  SAMPLE_OP = IR_WIDTH'(SAMPLE_OP4)
) (
  input  logic             TCK,
  input  logic             TRST,
  jtag_ir_param_if.slave   ir
);

  logic [IR_WIDTH-1:0] shift_q, shift_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic [IR_WIDTH-1:0] cap;

  // Status fills the bits above the fixed 01 pattern; IR_WIDTH=2 carries no status.
  always_comb begin
    cap      = '0;
    cap[1:0] = CAPTURE_LSB;
    for (int unsigned i = 2; i < IR_WIDTH; i++) begin
      cap[i] = ir.StatusIn[i-2];
    end
  end

`ifdef JTAG_IR_SHIFT_CHECK_EN
  localparam int unsigned CNT_W = $clog2(IR_WIDTH + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    shift_d = shift_q;
    instr_d = instr_q;
`ifdef JTAG_IR_SHIFT_CHECK_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    if (ir.TestLogicReset) begin
      instr_d = IDCODE_OP;
`ifdef JTAG_IR_SHIFT_CHECK_EN
      err_d   = 1'b0;
`endif
    end else begin
      if (ir.CaptureIR) begin
        shift_d = cap;
`ifdef JTAG_IR_SHIFT_CHECK_EN
        cnt_d   = '0;
`endif
      end else if (ir.ShiftIR) begin
        shift_d = {ir.TDI, shift_q[IR_WIDTH-1:1]};
`ifdef JTAG_IR_SHIFT_CHECK_EN
        if (cnt_q < CNT_W'(IR_WIDTH)) cnt_d = cnt_q + 1'b1;
`endif
      end
      // Update is independent of capture/shift and uses the pre-edge shift value.
      if (ir.UpdateIR) begin
`ifdef JTAG_IR_SHIFT_CHECK_EN
        cnt_d = '0;
        if (cnt_q < CNT_W'(IR_WIDTH)) begin
          err_d = 1'b1;
        end else begin
          instr_d = shift_q;
        end
`else
        instr_d = shift_q;
`endif
      end
    end
  end

  always_ff @(posedge TCK) begin
    if (!TRST) begin
      shift_q <= cap;
      instr_q <= IDCODE_OP;
`ifdef JTAG_IR_SHIFT_CHECK_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      instr_q <= instr_d;
`ifdef JTAG_IR_SHIFT_CHECK_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ir.TDO         = shift_q[0];
  assign ir.Instruction = instr_q;
`ifdef JTAG_IR_SHIFT_CHECK_EN
  assign ir.ShiftErr    = err_q;
`else
  assign ir.ShiftErr    = 1'b0;
`endif

  jtag_ir_decode #(
    .IR_WIDTH  (IR_WIDTH),
    .IDCODE_OP (IDCODE_OP),
    .SAMPLE_OP (SAMPLE_OP)
  ) u_decode (
    .instr      (instr_q),
    .sel_bypass (ir.SelBypass),
    .sel_idcode (ir.SelIdcode),
    .sel_sample (ir.SelSample),
    .sel_extest (ir.SelExtest)
  );

endmodule

// File: tb/tb_jtag_ir_param.sv
// Self-checking bench for jtag_ir_param (IR_WIDTH=4); expectations follow
// JTAG_IR_SHIFT_CHECK_EN when it is defined.
module tb_jtag_ir_param;

  logic tck;
  logic trst;

  jtag_ir_param_if #(.IR_WIDTH(4)) jif ();

  jtag_ir_param #(
    .IR_WIDTH  (4),
    .IDCODE_OP (4'b0010),
    .SAMPLE_OP (4'b0001)
  ) dut (
    .TCK  (tck),
    .TRST (trst),
    .ir   (jif)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  typedef struct packed {
    logic [3:0] instr;
    logic [3:0] sel;   // {bypass, idcode, sample, extest}
    logic       err;
  } ir_exp_t;

  logic    tdo_q[$];
  ir_exp_t ins_q[$];
  int      pass_cnt  = 0;
  int      total_cnt = 0;

  function automatic logic [3:0] ref_sel(input logic [3:0] op);
    if (op == 4'b0000)      return 4'b0001;
    else if (op == 4'b1111) return 4'b1000;
    else if (op == 4'b0010) return 4'b0100;
    else if (op == 4'b0001) return 4'b0010;
    else                    return 4'b1000;
  endfunction

  function automatic logic [3:0] dut_sel();
    return {jif.SelBypass, jif.SelIdcode, jif.SelSample, jif.SelExtest};
  endfunction

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic idle();
    jif.CaptureIR      = 1'b0;
    jif.ShiftIR        = 1'b0;
    jif.UpdateIR       = 1'b0;
    jif.TestLogicReset = 1'b0;
    jif.TDI            = 1'b0;
  endtask

  // Capture, shift n bits of v LSB first, then one UpdateIR cycle.
  task automatic load_ir(input logic [3:0] v, input int n);
    jif.CaptureIR = 1'b1;
    tick();
    jif.CaptureIR = 1'b0;
    jif.ShiftIR   = 1'b1;
    for (int i = 0; i < n; i++) begin
      jif.TDI = v[i];
      tick();
    end
    jif.ShiftIR  = 1'b0;
    jif.TDI      = 1'b0;
    jif.UpdateIR = 1'b1;
    tick();
    jif.UpdateIR = 1'b0;
  endtask

  task automatic check_ins(input string name);
    ir_exp_t e;
    e = ins_q.pop_front();
    total_cnt++;
    if (jif.Instruction !== e.instr)
      $display("FAIL %s instr: got %b want %b", name, jif.Instruction, e.instr);
    else pass_cnt++;
    total_cnt++;
    if (dut_sel() !== e.sel)
      $display("FAIL %s sel: got %b want %b", name, dut_sel(), e.sel);
    else pass_cnt++;
    total_cnt++;
    if (jif.ShiftErr !== e.err)
      $display("FAIL %s err: got %b want %b", name, jif.ShiftErr, e.err);
    else pass_cnt++;
  endtask

  task automatic check_tdo(input string name);
    logic e;
    e = tdo_q.pop_front();
    total_cnt++;
    if (jif.TDO !== e) $display("FAIL %s tdo: got %b want %b", name, jif.TDO, e);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    trst = 1'b0;
    jif.StatusIn = 2'b00;
    idle();
    tick();
    tick();
    ins_q.push_back('{4'b0010, 4'b0100, 1'b0});
    tdo_q.push_back(1'b1);
    check_ins("reset");
    check_tdo("reset");
    trst = 1'b1;
  endtask

  task automatic test_capture_shift();
    jif.StatusIn = 2'b10;
    jif.CaptureIR = 1'b1;
    tdo_q.push_back(1'b1);
    tick();
    check_tdo("cap_shift0");
    jif.CaptureIR = 1'b0;
    jif.ShiftIR   = 1'b1;
    jif.TDI       = 1'b0;
    tdo_q.push_back(1'b0);
    tdo_q.push_back(1'b0);
    tdo_q.push_back(1'b1);
    tdo_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_tdo("cap_shift");
    end
    idle();
  endtask

  task automatic test_load();
    logic [3:0] ops [6];
    ops = '{4'b0000, 4'b0101, 4'b1111, 4'b0001, 4'b0010, 4'b1010};
    for (int k = 0; k < 6; k++) begin
      ins_q.push_back('{ops[k], ref_sel(ops[k]), 1'b0});
      load_ir(ops[k], 4);
      check_ins("load");
    end
  endtask

  task automatic test_tlr();
    load_ir(4'b0001, 4);
    ins_q.push_back('{4'b0001, 4'b0010, 1'b0});
    check_ins("tlr_pre");
    // Leave 0000 in the shift register so a wrongly honoured update shows up.
    jif.CaptureIR = 1'b1;
    tick();
    jif.CaptureIR = 1'b0;
    jif.ShiftIR   = 1'b1;
    jif.TDI       = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    jif.ShiftIR        = 1'b0;
    jif.TestLogicReset = 1'b1;
    jif.UpdateIR       = 1'b1;
    ins_q.push_back('{4'b0010, 4'b0100, 1'b0});
    tick();
    idle();
    check_ins("tlr");
  endtask

  task automatic test_short_shift();
    jif.StatusIn = 2'b10;
`ifdef JTAG_IR_SHIFT_CHECK_EN
    ins_q.push_back('{4'b0010, 4'b0100, 1'b1});
    ins_q.push_back('{4'b0001, 4'b0010, 1'b1});
`else
    ins_q.push_back('{4'b1110, 4'b1000, 1'b0});
    ins_q.push_back('{4'b0001, 4'b0010, 1'b0});
`endif
    ins_q.push_back('{4'b0010, 4'b0100, 1'b0});
    load_ir(4'b0011, 2);
    check_ins("short");
    load_ir(4'b0001, 4);
    check_ins("short_full");
    jif.TestLogicReset = 1'b1;
    tick();
    idle();
    check_ins("short_tlr");
  endtask

  task automatic test_capture_shift_same();
    jif.StatusIn  = 2'b01;
    jif.ShiftIR   = 1'b1;
    jif.TDI       = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    jif.CaptureIR = 1'b1;
    jif.TDI       = 1'b0;
    tdo_q.push_back(1'b1);
    tdo_q.push_back(1'b0);
    tdo_q.push_back(1'b1);
    tdo_q.push_back(1'b0);
    tick();
    check_tdo("cap_wins");
    jif.CaptureIR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_tdo("cap_wins_out");
    end
    idle();
  endtask

  task automatic test_reset_mid_shift();
    load_ir(4'b0000, 4);
    jif.StatusIn  = 2'b10;
    jif.CaptureIR = 1'b1;
    tick();
    jif.CaptureIR = 1'b0;
    jif.ShiftIR   = 1'b1;
    jif.TDI       = 1'b0;
    tick();
    tick();
    trst = 1'b0;
    ins_q.push_back('{4'b0010, 4'b0100, 1'b0});
    tdo_q.push_back(1'b1);
    tick();
    check_ins("mid_rst");
    check_tdo("mid_rst");
    trst = 1'b1;
    tdo_q.push_back(1'b0);
    tdo_q.push_back(1'b0);
    tdo_q.push_back(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_tdo("mid_rst_out");
    end
    idle();
  endtask

  initial begin
    trst = 1'b0;
    jif.StatusIn = 2'b00;
    idle();
    test_reset();
    test_capture_shift();
    test_load();
    test_tlr();
    test_short_shift();
    test_capture_shift_same();
    test_reset_mid_shift();
    if (tdo_q.size() != 0 || ins_q.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", tdo_q.size(), ins_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
